mux4_rr_sched: RTL and testbench
================================

// Module: mux4_rr_sched
// PURPOSE
// - Round-robin scheduler that shares one 4:1 selector datapath among four requesters.
// - Drives the selector's 2-bit select (sel) and a one-hot grant (gnt) back to the requesters.
// - Bounds each grant to DWELL cycles so no requester starves the shared output.
// - Sits directly in front of the 4:1 select mux in the lab top level.
// PARAMETERS
// - DWELL  4  max consecutive cycles one grant is held; legal range 1..(2**CNT_W)-1
// - CNT_W  8  width of the dwell counter
// PORTS
// - clk   in   1      system clock; all state updates on posedge clk
// - rst   in   1      reset, synchronous, active-low (rst==0 at posedge clk resets)
// - req   in   4      request vector; req[i]=1 means requester i wants the selector
// - sel   out  2      select value to the 4:1 mux; index of current/last grant
// - gnt   out  4      one-hot grant, registered; all-zero when idle
// - busy  out  1      1 while any grant is active (busy == |gnt)
// - led   out  16     debug pattern (see CONFIGURATION)
// BEHAVIOUR
// - All outputs are registered. Reset values: sel=0, gnt=0, busy=0, led=16'h0001 (macro on) or 0.
// - Internal reset values: ptr=0 (next-priority index), cnt=0, state=IDLE.
// - FSM states: IDLE (no grant), GRANT (gnt[cur] held).
// - Arbitration: pick the first i with req[i]=1, searching ptr, ptr+1, ... ptr+3 (mod 4).
// - IDLE: if |req, at this edge gnt<=onehot(win), sel<=win, cnt<=0, go to GRANT; else stay.
// - Latency: req rising at edge N (with the block idle) -> gnt visible after edge N (1 cycle).
// - GRANT, release condition: req[cur]==0 OR cnt==DWELL-1.
// - GRANT, no release: cnt<=cnt+1; gnt and sel are unchanged.
// - GRANT, on release: ptr<=cur+1 (mod 4, wraps 3->0).
// - After release, arbitrate in the same edge using the new ptr (cur+1).
// - Release with a winner: grant it immediately, no idle bubble, cnt<=0.
// - The winner may be cur again if cur is the only requester (wrap). Each such regrant restarts the DWELL window.
// - Release with no winner: gnt<=0, busy<=0, go to IDLE; sel holds the last index.
// - DWELL==1: every active cycle rotates the grant among the current requesters.
// - Requests are level-sensitive and are not latched.
// - A request dropped before it is granted is lost; no queueing.
// - Simultaneous requests are resolved purely by ptr order.
// - Exactly one gnt bit is set, or none; sel always equals the index of the set bit when busy.
// - cnt never exceeds DWELL-1; counter arithmetic is unsigned CNT_W bits, no wrap in normal use.
// - rst low mid-grant: next edge forces all outputs and state to reset values regardless of req.
// - No X-propagation: an unknown req while rst is low must not affect state.
// CONFIGURATION
// - Macro MUX4_RR_LED_DBG_EN:
//   - Defined: led resets to 16'h0001.
//   - Defined: led rotates left by 1 (led[15] wraps to led[0]) on every edge that issues a new grant (IDLE->GRANT or release-with-winner, including regrant of cur).
//   - Defined: otherwise led holds its value.
//   - Undefined: led is constant 16'h0000.
//   - Undefined: no rotate register is synthesised.
// - Scheduling behaviour is identical with or without the macro.
// TESTING
// - Reset: rst=0 for 2 cycles with req=4'hF -> sel=0, gnt=0, busy=0, led=16'h0001 (macro on).
// - Single requester: req=4'b0100 from idle, DWELL=4 -> next cycle gnt=4'b0100, sel=2, busy=1.
//   - It holds 4 cycles, then regrants cur (ptr wraps to 3, search reaches 2).
//   - gnt stays 4'b0100 with cnt restarting.
// - All request: req=4'hF from reset, DWELL=2 -> gnt sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001.
//   - sel tracks 0,0,1,1,2,2,3,3,0.
// - Early release: req=4'b0011, drop req[0] one cycle after gnt=0001 -> gnt=0010 on the next edge.
//   - No idle bubble; busy stays 1.
// - Drain to idle: sole grant on 3, drop req to 0 -> gnt=0, busy=0 next cycle, sel stays 3.
//   - Then req=4'b1001 -> gnt=0001 (ptr=0 after the 3->0 wrap).
// - Reset mid-grant: gnt=0100 with cnt=1, assert rst=0 one cycle -> all outputs at reset values.
//   - Then req=4'b0100 -> gnt=0100 after 1 cycle; led=16'h0002 (macro on) / 16'h0000 (macro off).

Source files
------------

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler for a shared 4:1 selector. Each grant lasts at most DWELL cycles.
// Optional debug LED rotator is enabled by defining MUX4_RR_LED_DBG_EN.
module mux4_rr_sched #(
   parameter int unsigned DWELL = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   output logic [1:0]  sel,
   output logic [3:0]  gnt,
   output logic        busy,
   output logic [15:0] led
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

   state_t           r_state;
   logic [1:0]       r_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_sel;
   logic [3:0]       r_gnt;
   logic             r_busy;

   logic             w_release;
   logic [1:0]       w_base;
   logic [1:0]       w_idx;
   logic [1:0]       w_win;
   logic             w_found;

   // The search base is ptr while idle, and cur+1 on a release edge. That is
   // the value ptr is about to take, so the release edge can arbitrate immediately.
   always_comb begin
      // NOTE: every combinational output gets a default first; otherwise a latch is inferred.
      w_release = (r_state == GRANT) && (!req[r_sel] || (r_cnt == DWELL_LAST));
      w_base    = (r_state == GRANT) ? (r_sel + 2'd1) : r_ptr;
      w_found   = 1'b0;
      w_win     = w_base;
      w_idx     = w_base;
      for (int k = 3; k >= 0; k--) begin
         w_idx = w_base + 2'(k);
         if (req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      if (!rst) begin
         r_state <= IDLE;
         r_ptr   <= 2'd0;
         r_cnt   <= '0;
         r_sel   <= 2'd0;
         r_gnt   <= 4'd0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_gnt   <= 4'(1) << w_win;
                  r_sel   <= w_win;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= GRANT;
               end
            end
            GRANT: begin
               if (!w_release) begin
                  r_cnt <= r_cnt + 1'b1;
               end else begin
                  r_ptr <= w_base;
                  if (w_found) begin
                     r_gnt <= 4'(1) << w_win;
                     r_sel <= w_win;
                     r_cnt <= '0;
                  end else begin
                     r_gnt   <= 4'd0;
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign sel  = r_sel;
   assign gnt  = r_gnt;
   assign busy = r_busy;

`ifdef MUX4_RR_LED_DBG_EN
   logic        w_new_grant;
   logic [15:0] r_led;

   assign w_new_grant = w_found && ((r_state == IDLE) || w_release);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_led <= 16'h0001;
      end else if (w_new_grant) begin
         r_led <= {r_led[14:0], r_led[15]};
      end
   end

   assign led = r_led;
`else
   assign led = 16'h0000;
`endif

   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(r_gnt));
   a_busy_match  : assert property (@(posedge clk) disable iff (!rst) r_busy == (|r_gnt));
   a_sel_match   : assert property (@(posedge clk) disable iff (!rst) r_busy |-> r_gnt[r_sel]);
   a_cnt_bound   : assert property (@(posedge clk) disable iff (!rst) r_cnt <= DWELL_LAST);

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Scoreboard bench for mux4_rr_sched (DWELL=4). The stimulus pushes hand-computed expectations.
// A monitor one step after each rising edge pops them and compares.
module tb_mux4_rr_sched;

   typedef struct {
      logic [3:0]  gnt;
      logic [1:0]  sel;
      logic        busy;
      logic [15:0] led;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [1:0]  sel;
   logic [3:0]  gnt;
   logic        busy;
   logic [15:0] led;

   exp_t        exp_q[$];
   logic [15:0] exp_led;
   int          n_tests;
   int          n_fail;

   mux4_rr_sched #(.DWELL(4), .CNT_W(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .sel  (sel),
      .gnt  (gnt),
      .busy (busy),
      .led  (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle at the falling edge and queue the outputs expected after the next rising edge.
   task automatic step(input logic rst_v, input logic [3:0] req_v, input logic [3:0] gnt_e,
                       input logic [1:0] sel_e, input bit new_grant, input string name);
      exp_t e;
      @(negedge clk);
      rst = rst_v;
      req = req_v;
`ifdef MUX4_RR_LED_DBG_EN
      if (!rst_v)         exp_led = 16'h0001;
      else if (new_grant) exp_led = {exp_led[14:0], exp_led[15]};
`else
      exp_led = 16'h0000;
`endif
      e.gnt  = gnt_e;
      e.sel  = sel_e;
      e.busy = |gnt_e;
      e.led  = exp_led;
      e.name = name;
      exp_q.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if (gnt !== e.gnt || sel !== e.sel || busy !== e.busy || led !== e.led) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b sel=%0d busy=%b led=%h, want gnt=%b sel=%0d busy=%b led=%h",
                     e.name, gnt, sel, busy, led, e.gnt, e.sel, e.busy, e.led);
         end
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b0;
      req     = 4'h0;
      exp_led = 16'h0000;

      // Reset held two cycles with every request active
      step(1'b0, 4'hF, 4'b0000, 2'd0, 1'b0, "reset0");
      step(1'b0, 4'hF, 4'b0000, 2'd0, 1'b0, "reset1");

      // Single requester: 4-cycle window, then the same requester is granted again
      step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, "single_grant");
      step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, "single_hold1");
      step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, "single_hold2");
      step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, "single_hold3");
      step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, "single_regrant");
      step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, "single_restart");
      step(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, "single_drop");

      // Drain to idle from 3, then the ptr wrap to 0 picks requester 0 over 3
      step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, "grant3");
      step(1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0, "drain_idle");
      step(1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1, "wrap_ptr0");

      // Early release hands over with no idle bubble
      step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0, "early_hold");
      step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, "early_handover");
      step(1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, "early_idle");

      // All requesting from reset: each index holds 4 cycles, in order 0,1,2,3,0
      step(1'b0, 4'hF, 4'b0000, 2'd0, 1'b0, "all_reset");
      for (int k = 0; k < 17; k++) begin
         step(1'b1, 4'hF, 4'(1) << ((k / 4) % 4), 2'((k / 4) % 4), (k % 4) == 0,
              $sformatf("all_rr%0d", k));
      end

      // Reset while granted with cnt=1, then a fresh grant
      step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, "mid_grant");
      step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, "mid_cnt1");
      step(1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, "mid_reset");
      step(1'b0, 4'bxxxx, 4'b0000, 2'd0, 1'b0, "reset_xreq");
      step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, "post_reset_grant");

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
